// File: rtl/muldiv_pkg.sv
// Shared types, constants and operation-decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN     = 32;
    localparam int ITER_CNT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(input md_op_e op);
        case (op)
            OP_REM, OP_REMU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_a(input md_op_e op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Core-side request/response bundle of the multiply/divide unit.
interface muldiv_unit_if;
    import muldiv_pkg::*;

    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            wb_en;

    modport master (output start, kill, funct3, op_a, op_b, rd_in,
                    input  busy, done, result, rd_out, wb_en);
    modport slave  (input  start, kill, funct3, op_a, op_b, rd_in,
                    output busy, done, result, rd_out, wb_en);
endinterface

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
// o_hi/o_lo present the register values as they will be after the current step.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_last
);
    localparam int CW = $clog2(ITER_CNT);

    logic [XLEN-1:0] r_hi, r_lo, r_b;
    logic            r_div;
    logic [CW-1:0]   r_cnt;
    logic [XLEN:0]   w_sum, w_shift, w_diff;
    logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;

    // one iteration: hi:lo is the product accumulator or remainder:quotient pair
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b};
        if (r_div) begin
            if (w_diff[XLEN]) begin
                w_hi_nxt = w_shift[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end else begin
                w_hi_nxt = w_diff[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end
        end else begin
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // operand load and per-step register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= {XLEN{1'b0}};
            r_lo  <= {XLEN{1'b0}};
            r_b   <= {XLEN{1'b0}};
            r_div <= 1'b0;
            r_cnt <= {CW{1'b0}};
        end else if (i_load) begin
            r_hi  <= {XLEN{1'b0}};
            r_lo  <= i_a;
            r_b   <= i_b;
            r_div <= i_div;
            r_cnt <= {CW{1'b0}};
        end else if (i_step) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_hi  <= r_hi;
            r_lo  <= r_lo;
        end
    end

    assign o_hi   = w_hi_nxt;
    assign o_lo   = w_lo_nxt;
    assign o_last = (r_cnt == CW'(ITER_CNT - 1));
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit: FSM, special cases, sign correction, output registers.
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply for the MUL group.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    md_state_e         r_state, w_next_state;
    md_op_e            w_op, r_op;
    logic              r_neg_q, r_neg_r;
    logic [4:0]        r_rd_pend, r_rd_out, w_commit_rd;
    logic [XLEN-1:0]   r_result, w_commit_val, w_special_val, w_iter_val, w_fast_val;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_hi, w_lo;
    logic [2*XLEN-1:0] w_prod_s;
    logic              w_neg_a, w_neg_b, w_div0, w_ovf, w_special, w_fast_hit;
    logic              w_load, w_commit, w_last;

    assign w_op      = md_op_e'(bus.funct3);
    assign w_neg_a   = is_signed_a(w_op) & bus.op_a[XLEN-1];
    assign w_neg_b   = is_signed_b(w_op) & bus.op_b[XLEN-1];
    assign w_mag_a   = w_neg_a ? -bus.op_a : bus.op_a;
    assign w_mag_b   = w_neg_b ? -bus.op_b : bus.op_b;
    assign w_div0    = is_div(w_op) && (bus.op_b == {XLEN{1'b0}});
    assign w_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                       (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == {XLEN{1'b1}});
    assign w_special = w_div0 | w_ovf;

    // fixed results for divide-by-zero and signed overflow
    always_comb begin
        w_special_val = {XLEN{1'b0}};
        if (w_div0) begin
            w_special_val = is_rem(w_op) ? bus.op_a : {XLEN{1'b1}};
        end else if (w_op == OP_DIV) begin
            w_special_val = {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            w_special_val = {XLEN{1'b0}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fprod;
    assign w_fprod    = {{XLEN{w_neg_a}}, bus.op_a} * {{XLEN{w_neg_b}}, bus.op_b};
    assign w_fast_hit = !is_div(w_op);
    assign w_fast_val = (w_op == OP_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
    assign w_fast_hit = 1'b0;
    assign w_fast_val = {XLEN{1'b0}};
`endif

    muldiv_iter_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (r_state == ST_CALC),
        .i_div  (is_div(w_op)),
        .i_a    (w_mag_a),
        .i_b    (w_mag_b),
        .o_hi   (w_hi),
        .o_lo   (w_lo),
        .o_last (w_last)
    );

    // sign correction of the final iteration's magnitudes
    always_comb begin
        w_prod_s   = r_neg_q ? -{w_hi, w_lo} : {w_hi, w_lo};
        w_iter_val = {XLEN{1'b0}};
        case (r_op)
            OP_MUL:                        w_iter_val = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_iter_val = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_iter_val = r_neg_q ? -w_lo : w_lo;
            OP_REM, OP_REMU:               w_iter_val = r_neg_r ? -w_hi : w_hi;
            default:                       w_iter_val = {XLEN{1'b0}};
        endcase
    end

    // next-state and commit decisions
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        w_commit_val = w_iter_val;
        w_commit_rd  = r_rd_pend;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.kill) begin
                    w_commit_rd = bus.rd_in;
                    if (w_special) begin
                        w_next_state = ST_DONE;
                        w_commit     = 1'b1;
                        w_commit_val = w_special_val;
                    end else if (w_fast_hit) begin
                        w_next_state = ST_DONE;
                        w_commit     = 1'b1;
                        w_commit_val = w_fast_val;
                    end else begin
                        w_next_state = ST_CALC;
                        w_load       = 1'b1;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.kill) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                    w_commit     = 1'b1;
                end else begin
                    w_next_state = ST_CALC;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // operation context captured when an iterative operation starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_MUL;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rd_pend <= 5'd0;
        end else if (w_load) begin
            r_op      <= w_op;
            r_neg_q   <= w_neg_a ^ w_neg_b;
            r_neg_r   <= w_neg_a;
            r_rd_pend <= bus.rd_in;
        end else begin
            r_op      <= r_op;
        end
    end

    // committed result and destination, updated on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= {XLEN{1'b0}};
            r_rd_out <= 5'd0;
        end else if (w_commit) begin
            r_result <= w_commit_val;
            r_rd_out <= w_commit_rd;
        end else begin
            r_result <= r_result;
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;
    assign bus.rd_out = r_rd_out;
    assign bus.wb_en  = (r_state == ST_DONE) && (r_rd_out != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases, protocol cases and random operations.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    muldiv_unit_if bus();

    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc_cnt  = 0;
    int          n_done   = 0;
    logic [31:0] sb_res[$];
    logic [4:0]  sb_rd[$];
    logic [31:0] last_res = 32'h0;
    logic [4:0]  last_rd  = 5'd0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = ua * ub; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'h0)) return 0;
        if (((f == 3'b100) || (f == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 0;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 0;
`endif
        return 32;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // response side of the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (sb_res.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                last_res = sb_res.pop_front();
                last_rd  = sb_rd.pop_front();
                check_val("result", bus.result, last_res);
                check_val("rd_out", bus.rd_out, last_rd);
                check_val("wb_en", bus.wb_en, last_rd != 5'd0);
            end
        end
    end

    task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic expect_res);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        if (expect_res) begin
            sb_res.push_back(ref_model(f, a, b));
            sb_rd.push_back(rd);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op_a = $urandom; bus.op_b = $urandom; bus.rd_in = 5'($urandom); bus.funct3 = 3'($urandom);
    endtask

    task automatic wait_done(input int n0, input int lat, input string tag);
        while (!bus.done && ((cyc_cnt - n0) < 40)) begin
            @(posedge clk); #1;
        end
        check_val(tag, cyc_cnt - n0, lat);
        @(posedge clk); #1;
        check_val("idle_after_done", bus.busy, 1'b0);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n0;
        drive_start(f, a, b, rd, 1'b1);
        n0 = cyc_cnt;
        check_val("busy_after_start", bus.busy, 1'b1);
        wait_done(n0, exp_lat(f, a, b), "latency");
    endtask

    initial begin
        int n0, d0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = 3'b000;
        bus.op_a = 32'h0; bus.op_b = 32'h0; bus.rd_in = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_done", bus.done, 1'b0);
        check_val("rst_wb_en", bus.wb_en, 1'b0);
        check_val("rst_result", bus.result, 32'h0);
        check_val("rst_rd_out", bus.rd_out, 5'd0);
        @(negedge clk) rst_n = 1'b1;

        do_op(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd5);
        do_op(3'b110, 32'hFFFF_FFF9, 32'h2, 5'd6);
        do_op(3'b101, 32'h5, 32'h0, 5'd7);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
        do_op(3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd13);
        do_op(3'b100, 32'd100, 32'd7, 5'd0);

        // a second start while busy must not disturb the running divide
        drive_start(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd3, 1'b1);
        n0 = cyc_cnt;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd5; bus.op_b = 32'd6; bus.rd_in = 5'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n0, 32, "busy_start_latency");
        repeat (3) @(posedge clk);

        // kill mid-calculation: no done, outputs keep the last committed values
        drive_start(3'b101, 32'hDEAD_BEEF, 32'h1234, 5'd4, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_val("busy_before_kill", bus.busy, 1'b1);
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check_val("kill_busy", bus.busy, 1'b0);
        d0 = n_done;
        repeat (40) @(posedge clk);
        #1;
        check_val("kill_no_done", n_done - d0, 0);
        check_val("kill_result_hold", bus.result, last_res);
        check_val("kill_rd_hold", bus.rd_out, last_rd);

        // kill together with start in IDLE drops the start
        @(negedge clk);
        bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd10; bus.op_b = 32'd3; bus.rd_in = 5'd2;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        check_val("kill_start_busy", bus.busy, 1'b0);
        d0 = n_done;
        repeat (40) @(posedge clk);
        #1;
        check_val("kill_start_no_done", n_done - d0, 0);

        // asynchronous reset in the middle of a calculation
        drive_start(3'b100, 32'h1234_5678, 32'h77, 5'd15, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", bus.busy, 1'b0);
        check_val("midrst_done", bus.done, 1'b0);
        check_val("midrst_wb_en", bus.wb_en, 1'b0);
        check_val("midrst_result", bus.result, 32'h0);
        check_val("midrst_rd_out", bus.rd_out, 5'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op(3'b100, 32'h1234_5678, 32'h77, 5'd15);

        for (int i = 0; i < 200; i++) begin
            do_op(3'(i % 8), pick(), pick(), 5'($urandom));
        end

        repeat (3) @(posedge clk);
        check_val("scoreboard_empty", sb_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide unit for the single-cycle core. It takes the two register-file read operands and the destination register, iterates for up to 32 cycles while stalling the core via `busy`, and returns a result plus a one-cycle write-enable that drive the register-file write port (`WriteData`, `rd`, `RegWrite`). Decode raises `start` only for OP-class instructions with funct7 = 0000001.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation. Sampled only in IDLE.
- `kill`  in  1  synchronous abort of an in-flight operation (pipeline flush).
- `funct3`  in  3  RV32M operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value (ReadData1).
- `op_b`  in  XLEN  rs2 value (ReadData2).
- `rd_in`  in  5  destination register.
- `busy`  out  1  high when state is not IDLE. The core stalls its PC on `busy | start`.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  XLEN  registered result. Holds until the next accepted start.
- `rd_out`  out  5  registered destination register.
- `wb_en`  out  1  `done && rd_out != 0`. Drives RegWrite.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE to CALC on `start`. Operands, funct3 and rd are latched, and the count is set to 0.
  - IDLE to DONE directly for the special cases below, and for MUL-class operations when `MULDIV_FAST_MUL_EN` is defined.
  - CALC to DONE when the count reaches 31 and the 32nd iteration completes.
  - DONE to IDLE unconditionally.
- Datapath:
  - Signed operations work on magnitudes. MULHSU treats only `op_a` as signed.
  - Multiply uses a 64-bit shift-add accumulator, one multiplier bit per cycle. MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
  - Divide uses restoring shift-subtract, one quotient bit per cycle.
  - Sign correction is applied when entering DONE. Quotient sign is sign(a) XOR sign(b). Remainder takes the sign of the dividend.
- Special cases (1-cycle path, no CALC):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `op_a`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- `start` while `busy`: ignored, with no effect on the in-flight operation.
- `kill`:
  - In CALC or DONE, the next state is IDLE and `done`/`wb_en` do not pulse in any later cycle. `result` and `rd_out` keep their last committed values.
  - `kill` together with `start` in IDLE: kill wins and the start is dropped.
- Reset: asynchronous, in any state. Afterwards the state is IDLE and all outputs (`busy`, `done`, `wb_en`, `result`, `rd_out`) are 0.

## Timing
- Let the start edge be N, the rising edge at which `start` is sampled in IDLE.
- Iterative path:
  - `busy` is high from N through N+33.
  - Iterations occur at edges N+1 through N+32.
  - `done` is high for one cycle, between edges N+32 and N+33.
  - The unit is back in IDLE at N+33 and can accept a new start at N+34.
- 1-cycle path: `done` is high between edges N and N+1.
- `result` and `rd_out` update at the same edge on which `done` rises. Both are stable for the whole `done` cycle.
- All outputs are registered or derived only from state. There is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: the four MUL operations use a combinational 33x33 signed multiply and complete on the 1-cycle path.
  - Undefined: the four MUL operations use the 32-iteration shift-add path.
- Division is iterative in both builds.
- Results must be bit-identical between the two builds.

## Structure
- Shared package `muldiv_pkg` holds:
  - `XLEN` and `ITER_CNT` (= 32) constants.
  - `md_op_e` enum over funct3.
  - `md_state_e` enum (IDLE/CALC/DONE).
  - `is_div(md_op_e)` and `is_signed_a/b(md_op_e)` helper functions.
- One sub-module, `muldiv_iter_core`: the per-cycle shift-add / shift-subtract datapath (accumulator, quotient/remainder registers, iteration count). The top level keeps the FSM, special-case detection, sign correction and output registers.

## Test plan
- Reset mid-CALC (assert `rst_n` low at N+10) → outputs immediately 0, state IDLE. A new start after release completes normally.
- DIV 0xFFFFFFF9 (-7) / 2 → `result` = 0xFFFFFFFD (-3), `done` between N+32 and N+33. REM with the same operands → 0xFFFFFFFF (-1).
- DIVU 5 / 0 → 0xFFFFFFFF on the 1-cycle path. REM 0x80000000 / 0xFFFFFFFF → 0. DIV with the same operands → 0x80000000.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MUL → 0x00000001. Latency is 32 cycles without the macro and 1 cycle with it.
- Protocol checks:
  - `start` pulsed at N+5 while busy → ignored; the original result is returned unchanged.
  - `kill` at N+20 → no `done`, `busy` low at N+21.
  - `rd_in` = 0 → `done` pulses with `wb_en` = 0.
- Random 10k operations per funct3, against a reference model, in both macro builds.
